// File: rtl/imem_responder.sv
// Instruction-fetch responder: the memory side of a core's fetch port.
// A request is accepted in IDLE, the word is read from a preloadable RAM at
// the accept edge, and the response is presented after LATENCY cycles and
// held until the core takes it. A delivered all-zero instruction latches a
// sticky halt that blocks further requests until reset.
module imem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_inst,
    output logic                           rsp_err,
    input  logic                           prog_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] prog_idx,
    input  logic [31:0]                    prog_data,
    output logic [31:0]                    fetch_count,
    output logic                           halted
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [2:0] WAIT_INIT = 3'(LATENCY - 1);
    localparam logic       LAT_ONE   = (LATENCY == 1) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic        req_ready_s;
    logic        accept_s;
    logic        handshake_s;
    logic [2:0]  wait_cnt_r;
    logic [29:0] word_off_s;
    logic        addr_err_s;
    logic [31:0] read_data_s;
    logic        rsp_valid_r;
    logic [31:0] rsp_inst_r;
    logic        rsp_err_r;
    logic [31:0] fetch_count_r;
    logic        halted_r;
    logic [31:0] mem_r [DEPTH_WORDS];

    // Address decode: word offset from the base, range/alignment error, and the
    // RAM word it selects. BASE_ADDR is word aligned, so subtracting the word
    // parts gives the same offset bits as the full byte subtraction (wrapping).
    always_comb begin
        word_off_s  = req_addr[31:2] - BASE_ADDR[31:2];
        addr_err_s  = (req_addr[1:0] != 2'b00) ||
                      ({2'b00, word_off_s} >= 32'(DEPTH_WORDS));
        if (addr_err_s) begin
            read_data_s = 32'h0000_0000;
        end else begin
            read_data_s = mem_r[word_off_s[IDX_W-1:0]];
        end
    end

    // Next-state and handshake decode for the IDLE -> WAIT -> RESP -> IDLE cycle.
    always_comb begin
        state_nx_s  = state_r;
        req_ready_s = 1'b0;
        accept_s    = 1'b0;
        handshake_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_ready_s = !halted_r;
                if (req_valid && !halted_r) begin
                    accept_s = 1'b1;
                    if (LAT_ONE) begin
                        state_nx_s = ST_RESP;
                    end else begin
                        state_nx_s = ST_WAIT;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r <= 3'd1) begin
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    handshake_s = 1'b1;
                    state_nx_s  = ST_IDLE;
                end else begin
                    state_nx_s  = ST_RESP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register; rsp_valid is registered alongside it so it tracks RESP exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            rsp_valid_r <= (state_nx_s == ST_RESP);
        end
    end

    // Latency down-counter, loaded on accept and stepped while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 3'd0;
        end else if (accept_s) begin
            wait_cnt_r <= WAIT_INIT;
        end else if ((state_r == ST_WAIT) && (wait_cnt_r != 3'd0)) begin
            wait_cnt_r <= wait_cnt_r - 3'd1;
        end
    end

    // Response payload captured at the accept edge; later RAM writes cannot touch it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_inst_r <= 32'h0000_0000;
            rsp_err_r  <= 1'b0;
        end else if (accept_s) begin
            rsp_inst_r <= read_data_s;
            rsp_err_r  <= addr_err_s;
        end
    end

    // Completed-fetch counter and sticky halt on a delivered zero instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_r <= 32'h0000_0000;
            halted_r      <= 1'b0;
        end else if (handshake_s) begin
            fetch_count_r <= fetch_count_r + 32'd1;
            if ((rsp_inst_r == 32'h0000_0000) && !rsp_err_r) begin
                halted_r <= 1'b1;
            end
        end
    end

    // Program-load port; contents survive reset, and a same-edge fetch sees old data.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_r[prog_idx] <= prog_data;
        end
    end

    // req_ready is held low for the whole cycle in which reset is asserted.
    assign req_ready   = req_ready_s && !rst;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_inst    = rsp_inst_r;
    assign rsp_err     = rsp_err_r;
    assign fetch_count = fetch_count_r;
    assign halted      = halted_r;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (LATENCY 1, 3, 4) share a clock.
// Expected responses come from a bench-side RAM model and go through a
// scoreboard queue when a request is accepted; they are popped on response.
module tb_imem_responder;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst         [3];
    logic        req_valid   [3];
    logic        req_ready   [3];
    logic [31:0] req_addr    [3];
    logic        rsp_valid   [3];
    logic        rsp_ready   [3];
    logic [31:0] rsp_inst    [3];
    logic        rsp_err     [3];
    logic        prog_we     [3];
    logic [7:0]  prog_idx    [3];
    logic [31:0] prog_data   [3];
    logic [31:0] fetch_count [3];
    logic        halted      [3];

    logic [31:0] model_mem [3][256];
    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        imem_responder #(
            .DEPTH_WORDS(256),
            .LATENCY    ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
            .BASE_ADDR  (32'h8000_0000)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_addr   (req_addr[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_inst   (rsp_inst[g]),
            .rsp_err    (rsp_err[g]),
            .prog_we    (prog_we[g]),
            .prog_idx   (prog_idx[g]),
            .prog_data  (prog_data[g]),
            .fetch_count(fetch_count[g]),
            .halted     (halted[g])
        );
    end

    task automatic prog(input int d, input int idx, input logic [31:0] data);
        @(negedge clk);
        prog_we[d]   = 1'b1;
        prog_idx[d]  = 8'(idx);
        prog_data[d] = data;
        @(posedge clk);
        model_mem[d][idx] = data;
        #1;
        prog_we[d] = 1'b0;
    endtask

    // Present a request (optionally with a same-cycle RAM write) until accepted.
    task automatic issue(input int d, input logic [31:0] addr, input logic wr,
                         input int wr_idx, input logic [31:0] wr_data, output logic ok);
        exp_t        e;
        logic [31:0] off;
        int          n;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        prog_we[d]   = wr;
        prog_idx[d]  = 8'(wr_idx);
        prog_data[d] = wr_data;
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready[d];
        if (ok) begin
            off    = addr - 32'h8000_0000;
            e.err  = (addr[1:0] != 2'b00) || (off[31:2] >= 30'd256);
            e.inst = e.err ? 32'h0 : model_mem[d][off[9:2]];
            sb_q.push_back(e);
        end
        @(posedge clk);
        if (wr) model_mem[d][wr_idx] = wr_data;
        #1;
        req_valid[d] = 1'b0;
        prog_we[d]   = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid, hold off rsp_ready for 'hold' cycles, then take it.
    task automatic collect(input int d, input int hold, output logic [31:0] inst,
                           output logic err, output int lat, output logic stable,
                           output logic ok);
        lat    = 0;
        ok     = 1'b0;
        stable = 1'b1;
        inst   = 32'h0;
        err    = 1'b0;
        while (lat < 12 && !ok) begin
            @(negedge clk);
            lat++;
            ok = rsp_valid[d];
        end
        if (ok) begin
            inst = rsp_inst[d];
            err  = rsp_err[d];
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!rsp_valid[d] || rsp_inst[d] !== inst || rsp_err[d] !== err ||
                    req_ready[d] !== 1'b0) stable = 1'b0;
            end
            rsp_ready[d] = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready[d] = 1'b0;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (req_ready[d] !== 1'b0) begin
                n_fail++; $display("FAIL reset_ready_low[%0d]: got %b want 0", d, req_ready[d]);
            end
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (rsp_valid[d] !== 1'b0 || rsp_inst[d] !== 32'h0 || rsp_err[d] !== 1'b0 ||
                fetch_count[d] !== 32'h0 || halted[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got v=%b i=%h e=%b c=%0d h=%b want all zero",
                         d, rsp_valid[d], rsp_inst[d], rsp_err[d], fetch_count[d], halted[d]);
            end
            rst[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (req_ready[d] !== 1'b1) begin
                n_fail++; $display("FAIL reset_ready_high[%0d]: got %b want 1", d, req_ready[d]);
            end
        end
    endtask

    task automatic test_basic;
        logic [31:0] addrs [2];
        logic [31:0] inst;
        logic        err, stable, ok;
        int          lat;
        exp_t        e;
        addrs[0] = 32'h8000_0000;
        addrs[1] = 32'h8000_0004;
        prog(0, 0, 32'h4433_2211);
        prog(0, 1, 32'h0010_0093);
        for (int k = 0; k < 2; k++) begin
            issue(0, addrs[k], 1'b0, 0, 32'h0, ok);
            collect(0, 0, inst, err, lat, stable, ok);
            e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            n_checks++;
            if (!ok || inst !== e.inst || err !== e.err || lat !== 1) begin
                n_fail++;
                $display("FAIL basic_fetch%0d: got ok=%b inst=%h err=%b lat=%0d want inst=%h err=%b lat=1",
                         k, ok, inst, err, lat, e.inst, e.err);
            end
        end
        n_checks++;
        if (fetch_count[0] !== 32'd2) begin
            n_fail++; $display("FAIL basic_count: got %0d want 2", fetch_count[0]);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] inst;
        logic        err, stable, ok;
        int          lat;
        exp_t        e;
        prog(1, 0, 32'hCAFE_0001);
        issue(1, 32'h8000_0000, 1'b0, 0, 32'h0, ok);
        collect(1, 5, inst, err, lat, stable, ok);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        n_checks++;
        if (!ok || inst !== e.inst || err !== e.err || lat !== 3 || !stable) begin
            n_fail++;
            $display("FAIL backpressure: got ok=%b inst=%h err=%b lat=%0d stable=%b want inst=%h err=%b lat=3 stable=1",
                     ok, inst, err, lat, stable, e.inst, e.err);
        end
        n_checks++;
        if (fetch_count[1] !== 32'd1 || rsp_valid[1] !== 1'b0 || rsp_inst[1] !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL backpressure_release: got c=%0d v=%b i=%h want c=1 v=0 i=cafe0001",
                     fetch_count[1], rsp_valid[1], rsp_inst[1]);
        end
    endtask

    task automatic test_errors;
        logic [31:0] addrs [4];
        logic [31:0] inst;
        logic        err, stable, ok;
        int          lat;
        exp_t        e;
        addrs[0] = 32'h8000_0002;
        addrs[1] = 32'h8000_0400;
        addrs[2] = 32'h7FFF_FFFC;
        addrs[3] = 32'h8000_03FC;
        prog(0, 255, 32'h7777_AAAA);
        for (int k = 0; k < 4; k++) begin
            issue(0, addrs[k], 1'b0, 0, 32'h0, ok);
            collect(0, 0, inst, err, lat, stable, ok);
            e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            n_checks++;
            if (!ok || inst !== e.inst || err !== e.err || halted[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL err_fetch %h: got ok=%b inst=%h err=%b halted=%b want inst=%h err=%b halted=0",
                         addrs[k], ok, inst, err, halted[0], e.inst, e.err);
            end
        end
    endtask

    task automatic test_same_edge;
        logic [31:0] inst;
        logic        err, stable, ok;
        int          lat;
        exp_t        e;
        prog(0, 4, 32'h1111_1111);
        issue(0, 32'h8000_0010, 1'b1, 4, 32'hDEAD_BEEF, ok);
        collect(0, 0, inst, err, lat, stable, ok);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        n_checks++;
        if (!ok || inst !== e.inst || inst !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL same_edge_old: got ok=%b inst=%h want %h", ok, inst, e.inst);
        end
        issue(0, 32'h8000_0010, 1'b0, 0, 32'h0, ok);
        collect(0, 0, inst, err, lat, stable, ok);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        n_checks++;
        if (!ok || inst !== e.inst || inst !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL same_edge_new: got ok=%b inst=%h want %h", ok, inst, e.inst);
        end
    endtask

    task automatic test_halt;
        logic [31:0] inst;
        logic        err, stable, ok, blocked;
        int          lat;
        exp_t        e;
        prog(0, 2, 32'h0000_0000);
        issue(0, 32'h8000_0008, 1'b0, 0, 32'h0, ok);
        collect(0, 0, inst, err, lat, stable, ok);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        n_checks++;
        if (!ok || inst !== e.inst || err !== e.err || halted[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_set: got ok=%b inst=%h err=%b halted=%b want inst=%h err=%b halted=1",
                     ok, inst, err, halted[0], e.inst, e.err);
        end
        blocked = 1'b1;
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h8000_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b0) blocked = 1'b0;
        end
        n_checks++;
        if (!blocked) begin
            n_fail++; $display("FAIL halt_blocks: got req_ready=%b rsp_valid=%b want 0 0", req_ready[0], rsp_valid[0]);
        end
        req_valid[0] = 1'b0;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (halted[0] !== 1'b0 || fetch_count[0] !== 32'h0 || req_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_reset: got halted=%b count=%0d ready=%b want 0 0 0", halted[0], fetch_count[0], req_ready[0]);
        end
        rst[0] = 1'b0;
        #1;
        n_checks++;
        if (req_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL halt_ready_after_rst: got %b want 1", req_ready[0]);
        end
    endtask

    task automatic test_wait_reset;
        logic [31:0] inst;
        logic        err, stable, ok, quiet;
        int          lat;
        exp_t        e;
        prog(2, 3, 32'h0BAD_F00D);
        issue(2, 32'h8000_000C, 1'b0, 0, 32'h0, ok);
        if (sb_q.size() > 0) e = sb_q.pop_front();
        @(negedge clk);
        rst[2] = 1'b1;
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid[2] !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (!ok || !quiet || fetch_count[2] !== 32'h0) begin
            n_fail++;
            $display("FAIL wait_reset_drop: got accepted=%b quiet=%b count=%0d want 1 1 0", ok, quiet, fetch_count[2]);
        end
        issue(2, 32'h8000_000C, 1'b0, 0, 32'h0, ok);
        collect(2, 0, inst, err, lat, stable, ok);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        n_checks++;
        if (!ok || inst !== e.inst || err !== e.err || lat !== 4 || fetch_count[2] !== 32'd1) begin
            n_fail++;
            $display("FAIL wait_reset_refetch: got ok=%b inst=%h err=%b lat=%0d count=%0d want inst=%h err=%b lat=4 count=1",
                     ok, inst, err, lat, fetch_count[2], e.inst, e.err);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d]       = 1'b1;
            req_valid[d] = 1'b0;
            req_addr[d]  = 32'h0;
            rsp_ready[d] = 1'b0;
            prog_we[d]   = 1'b0;
            prog_idx[d]  = 8'h00;
            prog_data[d] = 32'h0;
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_errors();
        test_same_edge();
        test_halt();
        test_wait_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
